// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, imem req/ack reader and ir valid/ready presenter with redirect and halt.
// Optional IFETCH_STATS_EN adds fetch_count/stall_count ports.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] pc_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);
    typedef enum logic [2:0] {S_START, S_REQ, S_HOLD, S_DRAIN, S_HALTED} state_t;
    state_t      r_state, w_state_nxt;
    logic [31:0] r_fetch_pc, w_fetch_nxt, r_addr, r_ir, r_pc_out;
    logic        r_halt_pend, w_halt_pend_nxt, w_capture;
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_nxt     = r_fetch_pc;
        w_halt_pend_nxt = r_halt_pend;
        w_capture       = 1'b0;
        case (r_state)
            S_START: w_state_nxt = S_REQ;
            S_REQ: begin
                if (halt) begin
                    w_state_nxt     = imem_ack ? S_HALTED : S_DRAIN;
                    w_halt_pend_nxt = ~imem_ack;
                end else if (redirect_valid) begin
                    w_state_nxt = imem_ack ? S_REQ : S_DRAIN;
                    w_fetch_nxt = redirect_pc;
                end else if (imem_ack) begin
                    w_state_nxt = S_HOLD;
                    w_fetch_nxt = r_fetch_pc + 32'd1;
                    w_capture   = 1'b1;
                end
            end
            S_HOLD: begin
                if (halt) w_state_nxt = S_HALTED;
                else if (redirect_valid) begin
                    w_state_nxt = S_REQ;
                    w_fetch_nxt = redirect_pc;
                end else if (ir_ready) w_state_nxt = S_REQ;
            end
            S_DRAIN: begin
                if (redirect_valid) w_fetch_nxt = redirect_pc;
                w_halt_pend_nxt = r_halt_pend | halt;
                if (imem_ack) w_state_nxt = (r_halt_pend | halt) ? S_HALTED : S_REQ;
            end
            default: w_state_nxt = r_state;
        endcase
    end
    // r_addr freezes while draining so the abandoned request keeps its address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_START;
            r_fetch_pc  <= RESET_PC;
            r_addr      <= RESET_PC;
            r_ir        <= 32'd0;
            r_pc_out    <= 32'd0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            r_addr      <= (w_state_nxt == S_DRAIN) ? r_addr : w_fetch_nxt;
            if (w_capture) begin
                r_ir     <= imem_rdata;
                r_pc_out <= r_fetch_pc;
            end
        end
    end
    assign imem_req  = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem_addr = r_addr;
    assign ir        = r_ir;
    assign pc_out    = r_pc_out;
    assign ir_valid  = (r_state == S_HOLD) & ~redirect_valid;
    assign halted    = (r_state == S_HALTED);
`ifdef IFETCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (ir_valid && ir_ready) fetch_count <= fetch_count + 32'd1;
            if (imem_req && !imem_ack) stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random and directed stimulus against a program-order scoreboard and memory model.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h10;
    logic        clk = 1'b0;
    logic        reset_n, imem_req, imem_ack, ir_valid, ir_ready, redirect_valid, halt, halted;
    logic [31:0] imem_addr, imem_rdata, ir, pc_out, redirect_pc;
`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_count, stall_count;
`endif
    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .pc_out(pc_out), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
`ifdef IFETCH_STATS_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    int          n_vec = 0, n_err = 0, cyc = 0, prev_hs = 0, mem_waits = 0, wait_left = 0;
    int          n_fetch = 0, n_stall = 0;
    bit          outstanding = 0, chk_gap = 0, have_prev = 0, rand_waits = 0;
    logic [31:0] exp_pc, req_addr_q, last_pc, sv_ir, sv_pc, old_addr;
    logic [31:0] new_addrs[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One clock of stimulus; entered and left at posedge+1 with pulses low.
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt, input bit hlt);
        if (outstanding) begin
            chk("req_held", imem_req, 1);
            chk("addr_stable", imem_addr, req_addr_q);
        end else if (imem_req) begin
            chk("req_addr", imem_addr, exp_pc);
            req_addr_q = imem_addr;
            new_addrs.push_back(imem_addr);
            wait_left = rand_waits ? $urandom_range(0, 3) : mem_waits;
        end
        imem_ack       = imem_req && wait_left == 0;
        imem_rdata     = imem_ack ? word_of(req_addr_q) : $urandom;
        ir_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        halt           = hlt;
        #1;
        if (redir) chk("squash", ir_valid, 0);
        if (ir_valid && ir_ready) begin
            chk("pc_out", pc_out, exp_pc);
            chk("ir", ir, word_of(exp_pc));
            if (chk_gap && have_prev) chk("gap", cyc - prev_hs, 2);
            have_prev = 1;
            prev_hs   = cyc;
            last_pc   = pc_out;
            exp_pc    = exp_pc + 32'd1;
            n_fetch++;
        end
        if (imem_req && !imem_ack) begin
            n_stall++;
            wait_left--;
        end
        outstanding = imem_req && !imem_ack;
        if (redir && !hlt) exp_pc = tgt;
        @(posedge clk);
        #1;
        cyc++;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0;
        halt = 1'b0; imem_rdata = 32'd0; redirect_pc = 32'd0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_ir", ir, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_halted", halted, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        outstanding = 0; exp_pc = RST_PC; n_fetch = 0; n_stall = 0; have_prev = 0;
        new_addrs.delete();
        #1;
        chk("rel_req", imem_req, 0);
    endtask

    task automatic wait_newreq();
        for (int k = 0; k < 20 && !(imem_req && !outstanding); k++) cycle(1, 0, 0, 0);
        chk("to_newreq", imem_req && !outstanding, 1);
    endtask

    task automatic wait_hold();
        for (int k = 0; k < 20 && !ir_valid; k++) cycle(0, 0, 0, 0);
        chk("to_hold", ir_valid, 1);
    endtask

    task automatic wait_fetch();
        int n0 = n_fetch;
        for (int k = 0; k < 40 && n_fetch == n0; k++) cycle(1, 0, 0, 0);
        chk("to_fetch", n_fetch != n0, 1);
    endtask

    initial begin
        reset_n = 1'b1;
        #2;
        do_reset();
        repeat (8) begin
            chk_gap = 1;
            cycle(1, 0, 0, 0);
        end
        chk_gap = 0;
        chk("seq_len", new_addrs.size() >= 3, 1);
        for (int i = 0; i < 3; i++)
            if (i < new_addrs.size()) chk("seq_addr", new_addrs[i], RST_PC + i);

        wait_hold();
        sv_ir = ir;
        sv_pc = pc_out;
        repeat (5) begin
            cycle(0, 0, 0, 0);
            chk("bp_ir", ir, sv_ir);
            chk("bp_pc", pc_out, sv_pc);
            chk("bp_valid", ir_valid, 1);
            chk("bp_req", imem_req, 0);
        end
        cycle(1, 0, 0, 0);

        wait_hold();
        cycle(1, 1, 32'h80, 0);
        wait_fetch();
        chk("hold_redir_pc", last_pc, 32'h80);

        mem_waits = 3;
        wait_newreq();
        old_addr = imem_addr;
        cycle(1, 0, 0, 0);
        cycle(1, 1, 32'h40, 0);
        chk("drain_addr", imem_addr, old_addr);
        chk("drain_req", imem_req, 1);
        wait_fetch();
        chk("wait_redir_pc", last_pc, 32'h40);

        rand_waits = 1;
        repeat (1500) begin
            logic        busy = imem_req | ir_valid;
            logic [31:0] tgt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
            cycle($urandom_range(0, 3) != 0, busy && $urandom_range(0, 11) == 0, tgt, 0);
        end
        rand_waits = 0;
`ifdef IFETCH_STATS_EN
        chk("rand_fetch_cnt", fetch_count, n_fetch);
        chk("rand_stall_cnt", stall_count, n_stall);
`endif

        do_reset();
        mem_waits = 1;
        for (int k = 0; k < 40 && n_fetch < 4; k++) cycle(1, 0, 0, 0);
        chk("stat_fetches", n_fetch, 4);
`ifdef IFETCH_STATS_EN
        chk("stat_fetch_cnt", fetch_count, 4);
        chk("stat_stall_cnt", stall_count, 4);
`endif

        mem_waits = 2;
        wait_newreq();
        cycle(1, 0, 0, 1);
        chk("halt_w1", halted, 0);
        cycle(1, 0, 0, 0);
        chk("halt_w2", halted, 0);
        cycle(1, 0, 0, 0);
        chk("halt_done", halted, 1);
        repeat (5) begin
            cycle(1, 0, 0, 0);
            chk("halt_noreq", imem_req, 0);
            chk("halt_stay", halted, 1);
        end
        do_reset();
        mem_waits = 0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("restart_len", new_addrs.size(), 1);
        if (new_addrs.size() > 0) chk("restart_addr", new_addrs[0], RST_PC);
        chk("restart_halted", halted, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
